// File: rtl/mul_wb_pkg.sv
// mul_wb_pkg: shared widths and MUL-family funct3 encodings for the
// multiplier writeback slice.
package mul_wb_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int TAG_WIDTH  = 6;
  localparam int PREG_WIDTH = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011
  } mul_op_e;

endpackage : mul_wb_pkg

// File: rtl/mul_wb_fifo.sv
// mul_wb_fifo: generic synchronous FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of pointers and count
//   push/wdata : write at tail (ignored when full)
//   pop/rdata  : read head combinationally from storage, pop advances head
//   count      : current occupancy; empty when zero
module mul_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !clr));

endmodule : mul_wb_fifo

// File: rtl/mul_wb.sv
// mul_wb: writeback stage behind the two-stage multiplier.
//   flush                : squash in-flight and queued results
//   mul_en/opcode/tag/preg : issue side, tracked through MUL_LATENCY stages
//   mul_issue_ready      : credit; issue allowed only while high
//   mul_result(_valid)   : product returning from the multiplier
//   cdb_*                : head of the result queue, valid/ready handshake
//   err_sync             : sticky protocol-error flag
module mul_wb #(
  parameter int WORD_WIDTH            = mul_wb_pkg::WORD_WIDTH,
  parameter int PARTIAL_PRODUCT_WIDTH = 2 * (WORD_WIDTH + 1),
  parameter int TAG_WIDTH             = mul_wb_pkg::TAG_WIDTH,
  parameter int PREG_WIDTH            = mul_wb_pkg::PREG_WIDTH,
  parameter int MUL_LATENCY           = 2,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             mul_en,
  input  logic [2:0]                       mul_opcode,
  input  logic [TAG_WIDTH-1:0]             mul_rob_tag,
  input  logic [PREG_WIDTH-1:0]            mul_preg,
  output logic                             mul_issue_ready,
  input  logic [PARTIAL_PRODUCT_WIDTH-1:0] mul_result,
  input  logic                             mul_result_valid,
  output logic                             cdb_valid,
  input  logic                             cdb_ready,
  output logic [WORD_WIDTH-1:0]            cdb_data,
  output logic [TAG_WIDTH-1:0]             cdb_rob_tag,
  output logic [PREG_WIDTH-1:0]            cdb_preg,
  output logic                             err_sync
);

  import mul_wb_pkg::*;

  localparam int          ENTRY_W = WORD_WIDTH + TAG_WIDTH + PREG_WIDTH;
  localparam int          CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int          LAST    = MUL_LATENCY - 1;
  localparam int unsigned DEPTH_U = FIFO_DEPTH;

  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [2:0]             op_q   [MUL_LATENCY];
  logic [2:0]             op_d   [MUL_LATENCY];
  logic [TAG_WIDTH-1:0]   tag_q  [MUL_LATENCY];
  logic [TAG_WIDTH-1:0]   tag_d  [MUL_LATENCY];
  logic [PREG_WIDTH-1:0]  preg_q [MUL_LATENCY];
  logic [PREG_WIDTH-1:0]  preg_d [MUL_LATENCY];
  logic                   err_q, err_d;

  logic                   issue_ready;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [WORD_WIDTH-1:0]  sel_word;
  logic [ENTRY_W-1:0]     wdata;
  logic [ENTRY_W-1:0]     rdata;
  int unsigned            occupancy;
  logic                   unused_result_hi;

  assign unused_result_hi = ^mul_result[PARTIAL_PRODUCT_WIDTH-1:2*WORD_WIDTH];

  // Credit counts both queued results and results still in the multiplier,
  // so every accepted issue already owns a FIFO slot when its product lands.
  always_comb begin
    occupancy = 32'(fifo_count);
    for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
      occupancy = occupancy + {31'b0, vld_q[i]};
    end
    issue_ready = (occupancy < DEPTH_U);
  end

  always_comb begin
    vld_d[0]  = mul_en & issue_ready & ~flush;
    op_d[0]   = mul_opcode;
    tag_d[0]  = mul_rob_tag;
    preg_d[0] = mul_preg;
    for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1] & ~flush;
      op_d[i]   = op_q[i-1];
      tag_d[i]  = tag_q[i-1];
      preg_d[i] = preg_q[i-1];
    end
  end

  always_comb begin
    sel_word = '0;
    if (!op_q[LAST][2]) begin
      sel_word = (op_q[LAST] == OP_MUL) ? mul_result[WORD_WIDTH-1:0]
                                        : mul_result[2*WORD_WIDTH-1:WORD_WIDTH];
    end
    push  = vld_q[LAST] & ~flush;
    wdata = {sel_word, tag_q[LAST], preg_q[LAST]};
    pop   = ~fifo_empty & cdb_ready;
  end

  always_comb begin
    err_d = err_q
          | (vld_q[LAST] & ~mul_result_valid)
          | (vld_q[LAST] & op_q[LAST][2])
          | (mul_en & ~issue_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        op_q[i]   <= '0;
        tag_q[i]  <= '0;
        preg_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
      preg_q <= preg_d;
      err_q  <= err_d;
    end
  end

  mul_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign mul_issue_ready = issue_ready;
  assign cdb_valid       = ~fifo_empty;
  assign {cdb_data, cdb_rob_tag, cdb_preg} = rdata;
  assign err_sync        = err_q;

endmodule : mul_wb

// File: tb/tb_mul_wb.sv
module tb_mul_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        mul_en;
  logic [2:0]  mul_opcode;
  logic [5:0]  mul_rob_tag;
  logic [5:0]  mul_preg;
  logic        mul_issue_ready;
  logic [65:0] mul_result;
  logic        mul_result_valid;
  logic        cdb_valid;
  logic        cdb_ready;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_rob_tag;
  logic [5:0]  cdb_preg;
  logic        err_sync;

  logic [31:0] op_a, op_b;
  logic        m1_v = 1'b0, m2_v = 1'b0;
  logic [65:0] m1_p = '0,   m2_p = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_wb dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .mul_en           (mul_en),
    .mul_opcode       (mul_opcode),
    .mul_rob_tag      (mul_rob_tag),
    .mul_preg         (mul_preg),
    .mul_issue_ready  (mul_issue_ready),
    .mul_result       (mul_result),
    .mul_result_valid (mul_result_valid),
    .cdb_valid        (cdb_valid),
    .cdb_ready        (cdb_ready),
    .cdb_data         (cdb_data),
    .cdb_rob_tag      (cdb_rob_tag),
    .cdb_preg         (cdb_preg),
    .err_sync         (err_sync)
  );

  // Stand-in for the two-stage multiplier: 33-bit extended operands, 66-bit product.
  function automatic logic [65:0] mul_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [65:0] xa, xb;
    xa = (op == 3'b011) ? $signed({34'b0, a}) : $signed({{34{a[31]}}, a});
    xb = (op == 3'b000 || op == 3'b001) ? $signed({{34{b[31]}}, b}) : $signed({34'b0, b});
    return xa * xb;
  endfunction

  always @(posedge clk) begin
    m1_v <= mul_en;
    m1_p <= mul_model(mul_opcode, op_a, op_b);
    m2_v <= m1_v;
    m2_p <= m1_p;
  end

  assign mul_result       = m2_p;
  assign mul_result_valid = m2_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [5:0] p);
    mul_en      = 1'b1;
    mul_opcode  = op;
    op_a        = a;
    op_b        = b;
    mul_rob_tag = t;
    mul_preg    = p;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [5:0] p);
    drive(op, a, b, t, p);
    step();
    mul_en = 1'b0;
  endtask

  logic [2:0]  v_op  [5];
  logic [31:0] v_a   [5];
  logic [31:0] v_b   [5];
  logic [31:0] v_exp [5];
  int          accepted;

  initial begin
    v_op[0] = 3'b011; v_a[0] = 32'hFFFF_FFFF; v_b[0] = 32'hFFFF_FFFF; v_exp[0] = 32'hFFFF_FFFE;
    v_op[1] = 3'b001; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF; v_exp[1] = 32'h0000_0000;
    v_op[2] = 3'b010; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'hFFFF_FFFF; v_exp[2] = 32'hFFFF_FFFF;
    v_op[3] = 3'b011; v_a[3] = 32'h0001_0000; v_b[3] = 32'h0001_0000; v_exp[3] = 32'h0000_0001;
    v_op[4] = 3'b000; v_a[4] = 32'h0001_0003; v_b[4] = 32'h0001_0000; v_exp[4] = 32'h0003_0000;

    rst_n = 1'b0; flush = 1'b0; mul_en = 1'b0; mul_opcode = '0;
    mul_rob_tag = '0; mul_preg = '0; op_a = '0; op_b = '0; cdb_ready = 1'b0;
    step(); step();
    chk("rst_valid", cdb_valid, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_ready", mul_issue_ready, 1);
    chk("rst_err", err_sync, 0);
    rst_n = 1'b1;
    step();

    // Single MUL 7 * -3, result visible exactly at T+3 for one cycle.
    cdb_ready = 1'b1;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 6'd5, 6'd9);
    chk("t1_v_t1", cdb_valid, 0);
    step();
    chk("t1_v_t2", cdb_valid, 0);
    step();
    chk("t1_v_t3", cdb_valid, 1);
    chk("t1_data", cdb_data, 32'hFFFF_FFEB);
    chk("t1_tag", cdb_rob_tag, 5);
    chk("t1_preg", cdb_preg, 9);
    step();
    chk("t1_v_t4", cdb_valid, 0);

    // Word selection per opcode.
    for (int k = 0; k < 5; k++) begin
      issue(v_op[k], v_a[k], v_b[k], 6'(k + 1), 6'(k + 2));
      step(); step();
      chk("sel_valid", cdb_valid, 1);
      chk("sel_data", cdb_data, v_exp[k]);
      chk("sel_tag", cdb_rob_tag, 64'(k + 1));
      step();
    end

    // Backpressure: credits run out after FIFO_DEPTH accepted ops.
    cdb_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 8; i++) begin
      if (mul_issue_ready) begin
        drive(3'b000, 32'(accepted + 1), 32'd3, 6'(10 + accepted), 6'(accepted));
        accepted++;
      end else begin
        mul_en = 1'b0;
      end
      step();
    end
    mul_en = 1'b0;
    chk("bp_accepted", 64'(accepted), 4);
    chk("bp_ready", mul_issue_ready, 0);
    chk("bp_valid", cdb_valid, 1);
    chk("bp_hold_tag", cdb_rob_tag, 10);
    step();
    chk("bp_hold_tag2", cdb_rob_tag, 10);
    chk("bp_hold_data", cdb_data, 3);
    cdb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_v", cdb_valid, 1);
      chk("bp_drain_tag", cdb_rob_tag, 64'(10 + j));
      chk("bp_drain_data", cdb_data, 64'(3 * (j + 1)));
      step();
    end
    chk("bp_empty", cdb_valid, 0);
    chk("bp_ready_back", mul_issue_ready, 1);
    chk("bp_err", err_sync, 0);

    // Flush on the cycle the first of three products returns.
    drive(3'b000, 32'd2, 32'd2, 6'd30, 6'd1);
    step();
    drive(3'b000, 32'd3, 32'd2, 6'd31, 6'd2);
    step();
    drive(3'b000, 32'd4, 32'd2, 6'd32, 6'd3);
    flush = 1'b1;
    step();
    mul_en = 1'b0;
    flush  = 1'b0;
    chk("fl_ready", mul_issue_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("fl_no_valid", cdb_valid, 0);
      step();
    end
    issue(3'b000, 32'd6, 32'd7, 6'd33, 6'd4);
    step(); step();
    chk("fl_next_v", cdb_valid, 1);
    chk("fl_next_data", cdb_data, 42);
    chk("fl_next_tag", cdb_rob_tag, 33);
    step();
    chk("fl_err", err_sync, 0);

    // Issue without credit sets the sticky error and is never written back.
    cdb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(3'b000, 32'(i + 1), 32'd1, 6'(20 + i), 6'(i));
    end
    chk("er_ready", mul_issue_ready, 0);
    issue(3'b000, 32'd9, 32'd9, 6'd63, 6'd63);
    chk("er_set", err_sync, 1);
    cdb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("er_drain_tag", cdb_rob_tag, 64'(20 + j));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("er_no_rogue", cdb_valid, 0);
      step();
    end
    chk("er_sticky", err_sync, 1);

    // Asynchronous reset with two queued and two in flight.
    cdb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(3'b000, 32'(i + 5), 32'd1, 6'(40 + i), 6'(i + 1));
    end
    chk("rs_pre_valid", cdb_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", cdb_valid, 0);
    chk("rs_data", cdb_data, 0);
    chk("rs_tag", cdb_rob_tag, 0);
    chk("rs_preg", cdb_preg, 0);
    chk("rs_err", err_sync, 0);
    chk("rs_ready", mul_issue_ready, 1);
    step();
    rst_n     = 1'b1;
    cdb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("rs_no_stale", cdb_valid, 0);
      step();
    end
    chk("rs_err_after", err_sync, 0);
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 6'd50, 6'd7);
    step(); step();
    chk("rs_final_v", cdb_valid, 1);
    chk("rs_final_data", cdb_data, 1);
    chk("rs_final_tag", cdb_rob_tag, 50);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mul_wb
